// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target model.
package i2c_pkg;

  localparam int   I2C_ADDR_W = 7;
  localparam int   I2C_BYTE_W = 8;
  localparam logic I2C_ACK    = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ACK_ADDR,
    RX_BYTE,
    ACK_RX,
    TX_BYTE,
    WAIT_MACK
  } i2c_tgt_state_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes SCL/SDA into clk and derives edge and START/STOP pulses.
module i2c_bus_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic scl_meta, scl_sync, scl_hist;
  logic sda_meta, sda_sync, sda_hist;

  // Reset to the idle-bus level so no event fires straight out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_meta <= 1'b1;
      scl_sync <= 1'b1;
      scl_hist <= 1'b1;
      sda_meta <= 1'b1;
      sda_sync <= 1'b1;
      sda_hist <= 1'b1;
    end else begin
      scl_meta <= scl_i;
      scl_sync <= scl_meta;
      scl_hist <= scl_sync;
      sda_meta <= sda_i;
      sda_sync <= sda_meta;
      sda_hist <= sda_sync;
    end
  end

  assign sda_s    = sda_sync;
  assign scl_rise =  scl_sync & ~scl_hist;
  assign scl_fall = ~scl_sync &  scl_hist;
  assign start    =  scl_sync &  scl_hist &  sda_hist & ~sda_sync;
  assign stop     =  scl_sync &  scl_hist & ~sda_hist &  sda_sync;

endmodule

// File: rtl/i2c_target_model.sv
// I2C target with an internal register file and a write-observation port.
//
// state      | meaning
// IDLE       | bus free, or addressed to someone else until STOP
// ADDR       | shifting in the address/rw byte
// ACK_ADDR   | driving address ACK; next fall starts the data phase
// RX_BYTE    | shifting in a pointer or data byte
// ACK_RX     | driving ACK for a received byte
// TX_BYTE    | driving a register byte onto SDA
// WAIT_MACK  | sampling the controller's ACK/NACK after a sent byte
module i2c_target_model
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] TARGET_ADDR = 7'h50,
  parameter int DEPTH = 8,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scl_i,
  input  logic                  sda_i,
  output logic                  sda_o,
  output logic                  sda_o_en,
  output logic                  busy,
  output logic                  wr_valid,
  output logic [PW-1:0]         wr_addr,
  output logic [I2C_BYTE_W-1:0] wr_data
);

  logic sda_s, scl_rise, scl_fall, start, stop;

  i2c_bus_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .sda_s    (sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  i2c_tgt_state_t        state_q, state_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [I2C_BYTE_W-1:0] shift_q, shift_d;
  logic                  rw_q, rw_d;
  logic                  first_q, first_d;
  logic                  mack_q, mack_d;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic                  sda_en_q, sda_en_d;
  logic                  busy_q, busy_d;
  logic                  wr_valid_q, wr_valid_d;
  logic [PW-1:0]         wr_addr_q, wr_addr_d;
  logic [I2C_BYTE_W-1:0] wr_data_q, wr_data_d;
  logic                  mem_we;
  logic [I2C_BYTE_W-1:0] rx_byte, tx_load;
  logic [I2C_BYTE_W-1:0] mem [DEPTH];

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rw_d       = rw_q;
    first_d    = first_q;
    mack_d     = mack_q;
    ptr_d      = ptr_q;
    sda_en_d   = sda_en_q;
    busy_d     = busy_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    mem_we     = 1'b0;
    rx_byte    = {shift_q[I2C_BYTE_W-2:0], sda_s};
    tx_load    = mem[ptr_q];

    if (stop) begin
      state_d  = IDLE;
      sda_en_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start) begin
      state_d   = ADDR;
      bit_cnt_d = 4'd0;
      shift_d   = '0;
      sda_en_d  = 1'b0;
      busy_d    = 1'b1;
    end else begin
      case (state_q)
        ADDR: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              if (rx_byte[I2C_BYTE_W-1:1] == TARGET_ADDR) begin
                state_d = ACK_ADDR;
                rw_d    = rx_byte[0];
              end else begin
                state_d = IDLE;
              end
            end
          end
        end
        // bit_cnt 0 -> first fall (drive ACK), 1 -> fall ending the ACK clock
        ACK_ADDR: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd0) begin
              sda_en_d  = 1'b1;
              bit_cnt_d = 4'd1;
            end else if (rw_q) begin
              state_d   = TX_BYTE;
              shift_d   = {tx_load[I2C_BYTE_W-2:0], 1'b0};
              sda_en_d  = ~tx_load[I2C_BYTE_W-1];
              ptr_d     = ptr_q + 1'b1;
              bit_cnt_d = 4'd1;
            end else begin
              state_d   = RX_BYTE;
              sda_en_d  = 1'b0;
              bit_cnt_d = 4'd0;
              first_d   = 1'b1;
            end
          end
        end
        RX_BYTE: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              state_d   = ACK_RX;
              bit_cnt_d = 4'd0;
              if (first_q) begin
                ptr_d = rx_byte[PW-1:0];
              end else begin
                mem_we     = 1'b1;
                wr_valid_d = 1'b1;
                wr_addr_d  = ptr_q;
                wr_data_d  = rx_byte;
                ptr_d      = ptr_q + 1'b1;
              end
            end
          end
        end
        ACK_RX: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd0) begin
              sda_en_d  = 1'b1;
              bit_cnt_d = 4'd1;
            end else begin
              sda_en_d  = 1'b0;
              first_d   = 1'b0;
              state_d   = RX_BYTE;
              bit_cnt_d = 4'd0;
            end
          end
        end
        // bit_cnt counts bits already placed on SDA
        TX_BYTE: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_en_d = 1'b0;
              mack_d   = ~I2C_ACK;
              state_d  = WAIT_MACK;
            end else begin
              sda_en_d  = ~shift_q[I2C_BYTE_W-1];
              shift_d   = {shift_q[I2C_BYTE_W-2:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        WAIT_MACK: begin
          if (scl_rise) begin
            mack_d = sda_s;
          end else if (scl_fall && mack_q == I2C_ACK) begin
            state_d   = TX_BYTE;
            shift_d   = {tx_load[I2C_BYTE_W-2:0], 1'b0};
            sda_en_d  = ~tx_load[I2C_BYTE_W-1];
            ptr_d     = ptr_q + 1'b1;
            bit_cnt_d = 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 4'd0;
      shift_q    <= '0;
      rw_q       <= 1'b0;
      first_q    <= 1'b0;
      mack_q     <= ~I2C_ACK;
      ptr_q      <= '0;
      sda_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rw_q       <= rw_d;
      first_q    <= first_d;
      mack_q     <= mack_d;
      ptr_q      <= ptr_d;
      sda_en_q   <= sda_en_d;
      busy_q     <= busy_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (mem_we) begin
      mem[ptr_q] <= rx_byte;
    end
  end

  assign sda_o    = 1'b0;
  assign sda_o_en = sda_en_q;
  assign busy     = busy_q;
  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_i2c_target_model.sv
// Bus-level bench: a behavioural I2C controller drives the target, a memory model predicts results.
module tb_i2c_target_model;
  import i2c_pkg::*;

  localparam int Q = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_line;
  logic       sda_o, sda_o_en, busy, wr_valid;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;

  int total = 0;
  int bad   = 0;

  logic [7:0]  mmem [8];
  logic [2:0]  mptr;
  logic [10:0] exp_q[$];
  logic [10:0] obs_q[$];
  logic [7:0]  tx_q[$];
  int          consec = 0;
  logic        wv_prev = 1'b0;
  logic        en_seen = 1'b0;

  assign sda_line = sda_m & ~sda_o_en;

  always #5 clk = ~clk;

  i2c_target_model dut (
    .clk      (clk),
    .rst      (rst),
    .scl_i    (scl_m),
    .sda_i    (sda_line),
    .sda_o    (sda_o),
    .sda_o_en (sda_o_en),
    .busy     (busy),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  always @(negedge clk) begin
    if (wr_valid) obs_q.push_back({wr_addr, wr_data});
    if (wr_valid && wv_prev) consec++;
    wv_prev = wr_valid;
    if (sda_o_en) en_seen = 1'b1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_c();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic stop_c();
    scl_m = 1'b0; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b;    tick(Q);
    scl_m = 1'b1; tick(2*Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    b = sda_line; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] v, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) write_bit(v[i]);
    read_bit(b);
    ack = (b == 1'b0);
  endtask

  task automatic read_byte(input logic send_ack, output logic [7:0] v);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      v[i] = b;
    end
    write_bit(send_ack ? 1'b0 : 1'b1);
  endtask

  task automatic check_wr(input string tag);
    int n;
    chk({tag, "_wr_cnt"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_wr"}, obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  // Pointer byte p followed by the bytes in tx_q.
  task automatic do_write(input logic [7:0] p, input string tag);
    logic ack;
    start_c();
    write_byte(8'hA0, ack); chk({tag, "_aack"}, ack, 1);
    write_byte(p, ack);     chk({tag, "_pack"}, ack, 1);
    mptr = p[2:0];
    foreach (tx_q[i]) begin
      write_byte(tx_q[i], ack);
      chk({tag, "_dack"}, ack, 1);
      exp_q.push_back({mptr, tx_q[i]});
      mmem[mptr] = tx_q[i];
      mptr = mptr + 3'd1;
    end
    stop_c();
    check_wr(tag);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // Read n bytes, optionally after setting the pointer; last byte NACKed.
  task automatic do_read(input logic use_ptr, input logic [7:0] p, input int n, input string tag);
    logic       ack;
    logic [7:0] v;
    start_c();
    if (use_ptr) begin
      write_byte(8'hA0, ack); chk({tag, "_aack"}, ack, 1);
      write_byte(p, ack);     chk({tag, "_pack"}, ack, 1);
      mptr = p[2:0];
      start_c();
    end
    write_byte(8'hA1, ack); chk({tag, "_rack"}, ack, 1);
    for (int i = 0; i < n; i++) begin
      read_byte(i != n - 1, v);
      chk({tag, "_data"}, v, mmem[mptr]);
      mptr = mptr + 3'd1;
    end
    chk({tag, "_released"}, sda_o_en, 0);
    stop_c();
    check_wr(tag);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    logic ack;
    logic [2:0] ptr_before;
    for (int i = 0; i < 8; i++) mmem[i] = 8'h00;
    mptr = 3'd0;
    tick(3);
    chk("rst_en", sda_o_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wrv", wr_valid, 0);
    chk("rst_wra", wr_addr, 0);
    chk("rst_wrd", wr_data, 0);
    rst = 1'b0;
    tick(4);
    chk("sda_o", sda_o, 0);

    tx_q = '{8'h11, 8'h22};
    do_write(8'h02, "burst");
    chk("burst_ptr", dut.ptr_q, 3'd4);

    do_read(1'b1, 8'h02, 2, "rdback");

    en_seen = 1'b0;
    start_c();
    write_byte(8'hA4, ack); chk("mm_aack", ack, 0);
    chk("mm_busy_mid", busy, 1);
    write_byte(8'h55, ack); chk("mm_dack", ack, 0);
    stop_c();
    chk("mm_en_seen", en_seen, 0);
    check_wr("mm");
    do_read(1'b1, 8'h02, 2, "mm_mem");

    tx_q = '{8'hAA, 8'hBB};
    do_write(8'h07, "wrap");
    do_read(1'b1, 8'h07, 2, "wrap_rd");

    ptr_before = mptr;
    start_c();
    write_byte(8'hA0, ack); chk("smid_aack", ack, 1);
    tick(Q);
    en_seen = 1'b0;
    write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
    stop_c();
    chk("smid_state", dut.state_q, IDLE);
    chk("smid_ptr", dut.ptr_q, ptr_before);
    chk("smid_en", en_seen, 0);
    chk("smid_busy", busy, 0);

    tx_q = '{8'h3C};
    do_write(8'h00, "pre_rst");
    start_c();
    write_byte(8'hA0, ack);
    write_byte(8'h00, ack);
    start_c();
    write_byte(8'hA1, ack); chk("rmid_rack", ack, 1);
    chk("rmid_drv0", sda_o_en, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rmid_en", sda_o_en, 0);
    chk("rmid_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) mmem[i] = 8'h00;
    mptr = 3'd0;
    stop_c();
    tx_q.delete();
    do_write(8'h00, "post_rst");
    do_read(1'b1, 8'h00, 1, "post_rst_rd");

    for (int it = 0; it < 15; it++) begin
      int op, n;
      logic [7:0] p;
      op = $urandom_range(0, 2);
      n  = $urandom_range(1, 3);
      p  = 8'($urandom_range(0, 255));
      case (op)
        0: begin
          tx_q.delete();
          for (int k = 0; k < n; k++) tx_q.push_back(8'($urandom_range(0, 255)));
          do_write(p, "rnd_wr");
        end
        1: do_read(1'b1, p, n, "rnd_rd");
        default: do_read(1'b0, p, n, "rnd_cur");
      endcase
    end

    chk("wrv_consec", consec, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
